// File: rtl/ps2_pkg.sv
// Shared PS/2 frame layout, decoder state encoding and frame validation helper.
package ps2_pkg;

    localparam int unsigned PS2_START   = 0;
    localparam int unsigned PS2_D_LSB   = 1;
    localparam int unsigned PS2_D_MSB   = 8;
    localparam int unsigned PS2_PAR     = 9;
    localparam int unsigned PS2_STOP    = 10;
    localparam int unsigned PS2_FRAME_W = 11;
    localparam int unsigned PS2_DATA_W  = PS2_D_MSB - PS2_D_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_CHECK   = 2'd3
    } ps2_state_e;

    // Start low, stop high, odd parity across data and parity bits.
    function automatic logic frame_ok(input logic [PS2_FRAME_W-1:0] f);
        return ~f[PS2_START] & f[PS2_STOP] & (^f[PS2_PAR:PS2_D_LSB]);
    endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// Small synchronous FIFO with a registered head word and registered valid flag.
module ps2_code_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic             o_full_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;

    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] w_rd_nxt;

    assign w_pop       = r_valid & i_pop;
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_push      = i_push & (~w_full | w_pop);
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_rd_nxt    = r_rd_ptr + PTR_W'(1);

    // Head is preloaded so the consumer sees the next word the cycle after a pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= w_rd_nxt;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != CNT_W'(0));
            if (w_push && ((r_count - CNT_W'(w_pop)) == CNT_W'(0)))
                r_head <= i_data;
            else if (w_pop)
                r_head <= r_mem[w_rd_nxt];
        end
    end

    assign o_head   = r_head;
    assign o_valid  = r_valid;
    assign o_full_c = w_full;

endmodule

// File: rtl/ps2_frame_decoder.sv
// Frames PS/2 traffic by counting synchronised ps2_clk falls, validates each
// 11-bit frame and queues good scan codes for a valid/ready consumer.
module ps2_frame_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 5000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ps2_clk,
    input  logic [PS2_FRAME_W-1:0] frame,
    output logic [PS2_DATA_W-1:0]  code,
    output logic                   code_valid,
    input  logic                   code_ready,
    output logic                   frame_err,
    output logic                   timeout,
    output logic                   overflow,
    output logic                   busy
);
    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned BCN_W = 4;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_last;
    ps2_state_e             r_state;
    logic [BCN_W-1:0]       r_bitcnt;
    logic [TMR_W-1:0]       r_timer;
    logic [PS2_FRAME_W-1:0] r_frame_q;
    logic                   r_frame_err;
    logic                   r_timeout;
    logic                   r_overflow;
    logic                   r_busy;

    logic w_fall;
    logic w_ok;
    logic w_push;
    logic w_pop;
    logic w_full;

    // Preset high so a line idling high after reset produces no false fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync      <= '1;
            r_sync_last <= 1'b1;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], ps2_clk};
            r_sync_last <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall = r_sync_last & ~r_sync[SYNC_STAGES-1];
    assign w_ok   = frame_ok(r_frame_q);
    assign w_pop  = code_valid & code_ready;
    assign w_push = (r_state == ST_CHECK) & w_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= '0;
            r_timer     <= '0;
            r_frame_q   <= '0;
            r_frame_err <= 1'b0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_bitcnt <= BCN_W'(1);
                        r_timer  <= '0;
                        r_state  <= ST_RECV;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (w_fall) begin
                        r_bitcnt <= r_bitcnt + BCN_W'(1);
                        r_timer  <= '0;
                        if (r_bitcnt == BCN_W'(PS2_FRAME_W - 1)) r_state <= ST_CAPTURE;
                    end else if (r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        r_timeout <= 1'b1;
                        r_bitcnt  <= '0;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    r_frame_q <= frame;
                    r_state   <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_ok) r_overflow  <= w_full & ~w_pop;
                    else      r_frame_err <= 1'b1;
                    r_bitcnt <= '0;
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    ps2_code_fifo #(
        .WIDTH (PS2_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_data   (r_frame_q[PS2_D_MSB:PS2_D_LSB]),
        .i_pop    (code_ready),
        .o_head   (code),
        .o_valid  (code_valid),
        .o_full_c (w_full)
    );

    assign frame_err = r_frame_err;
    assign timeout   = r_timeout;
    assign overflow  = r_overflow;
    assign busy      = r_busy;

endmodule
